div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/div_sequencer_if.sv | 26 ++
 rtl/div_step.sv | 23 ++
 rtl/div_sequencer.sv | 115 +++++++++++
 tb/tb_div_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the iterative divide unit: operation select, FSM states
// and small decode helpers used by both the datapath and its interface.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_SIGN = 2'b10,
    S_DONE = 2'b11
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the pipeline and the divide sequencer.
interface div_sequencer_if
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            start;
  div_op_e         op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, dividend, divisor, flush,
    input  stall, busy, valid, result
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output stall, busy, valid, result
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor and keep the difference when it does not go negative.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0]   shifted_rem;
  logic [XLEN+1:0] diff;
  logic            neg;

  // Two guard bits: the shifted remainder needs XLEN+1, the borrow one more.
  assign shifted_rem = {rem_in, quo_in[XLEN-1]};
  assign diff        = {1'b0, shifted_rem} - {2'b00, dvs};
  assign neg         = diff[XLEN+1];

  assign rem_out = neg ? shifted_rem[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], ~neg};
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RISC-V style divider: fast path for divide-by-zero and signed
// overflow, otherwise XLEN restoring steps followed by a sign-fixup cycle.
module div_sequencer
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  div_sequencer_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;
  logic [CW-1:0]   cnt_q;
  logic            is_rem_q, neg_q;

  logic            accept, sgn, div_zero, overflow, fast;
  logic [XLEN-1:0] fast_res, mag_a, mag_b, rem_n, quo_n, fix_val;

  assign accept   = (state_q == S_IDLE) && bus.start && !bus.flush;
  assign sgn      = op_is_signed(bus.op);
  assign div_zero = (bus.divisor == '0);
  assign overflow = sgn && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
  assign fast     = div_zero || overflow;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    fast_res = '0;
    if (div_zero)
      fast_res = op_is_rem(bus.op) ? bus.dividend : '1;
    else if (overflow)
      fast_res = op_is_rem(bus.op) ? '0 : MIN_NEG;
  end

  assign mag_a = (sgn && bus.dividend[XLEN-1]) ? (~bus.dividend + 1'b1) : bus.dividend;
  assign mag_b = (sgn && bus.divisor[XLEN-1])  ? (~bus.divisor  + 1'b1) : bus.divisor;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvs     (dvs_q),
    .rem_out (rem_n),
    .quo_out (quo_n)
  );

  always_comb begin
    fix_val = is_rem_q ? rem_q : quo_q;
    if (neg_q) fix_val = ~fix_val + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = fast ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CW'(XLEN - 1)) state_d = S_SIGN;
      S_SIGN: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (fast) begin
              result_q <= fast_res;
            end else begin
              rem_q    <= '0;
              quo_q    <= mag_a;
              dvs_q    <= mag_b;
              cnt_q    <= '0;
              is_rem_q <= op_is_rem(bus.op);
              // Quotient sign follows both operands, remainder the dividend.
              neg_q    <= sgn && (op_is_rem(bus.op) ? bus.dividend[XLEN-1]
                                 : (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]));
            end
          end
        end
        S_CALC: begin
          if (!bus.flush) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_SIGN: if (!bus.flush) result_q <= fix_val;
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.valid  = (state_q == S_DONE) && !bus.flush;
  assign bus.stall  = accept || (state_q == S_CALC) || (state_q == S_SIGN);
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomized checks of div_sequencer against an arithmetic
// reference model of RISC-V divide/remainder semantics.
module tb_div_sequencer;
  import cpu_pkg::*;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] MIN_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [XLEN-1:0] last_res = '0;

  always #5 clk = ~clk;

  div_sequencer_if #(.XLEN(XLEN)) bus ();

  div_sequencer #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [XLEN-1:0] ref_result(div_op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic s = (op == OP_DIV) || (op == OP_REM);
    logic r = (op == OP_REM) || (op == OP_REMU);
    if (b == 0) return r ? a : '1;
    if (s && a == MIN_NEG && b == '1) return r ? '0 : MIN_NEG;
    case (op)
      OP_DIV:  return $signed(a) / $signed(b);
      OP_REM:  return $signed(a) % $signed(b);
      OP_DIVU: return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(div_op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic s = (op == OP_DIV) || (op == OP_REM);
    if (b == 0 || (s && a == MIN_NEG && b == '1)) return 1;
    return XLEN + 2;
  endfunction

  // Starts an operation in the next cycle N and waits for its valid pulse.
  task automatic run_op(input string tag, input div_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] exp = ref_result(op, a, b);
    int lat = ref_latency(op, a, b);
    int k = 0;
    logic seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.dividend = a; bus.divisor = b;
    #1;
    check({tag, " stall@N"}, XLEN'(bus.stall), 1);
    check({tag, " valid@N"}, XLEN'(bus.valid), 0);
    while (!seen && k < XLEN + 8) begin
      @(negedge clk);
      bus.start = 1'b0;
      k++;
      #1;
      if (bus.valid) seen = 1'b1;
      else if (bus.stall !== (k < lat)) check({tag, " stall pre-valid"}, XLEN'(bus.stall), XLEN'(k < lat));
    end
    check({tag, " latency"}, seen ? XLEN'(k) : '1, XLEN'(lat));
    check({tag, " result"}, bus.result, exp);
    check({tag, " stall@valid"}, XLEN'(bus.stall), 0);
    last_res = exp;
  endtask

  task automatic count_valid(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (bus.valid) pulses++;
    end
  endtask

  initial begin
    int pulses, first;
    bus.start = 1'b0; bus.op = OP_DIV; bus.dividend = '0; bus.divisor = '0; bus.flush = 1'b0;
    #1;
    check("reset valid", XLEN'(bus.valid), 0);
    check("reset busy", XLEN'(bus.busy), 0);
    check("reset stall", XLEN'(bus.stall), 0);
    check("reset result", bus.result, 0);
    @(negedge clk); rst = 1'b0;

    run_op("div 100/7", OP_DIV, 100, 7);
    run_op("rem 100/7", OP_REM, 100, 7);
    run_op("div -7/2", OP_DIV, -32'sd7, 2);
    run_op("rem -7/2", OP_REM, -32'sd7, 2);
    run_op("divu ffffffff/2", OP_DIVU, 32'hFFFF_FFFF, 2);
    run_op("divu 5/0", OP_DIVU, 5, 0);
    run_op("remu 5/0", OP_REMU, 5, 0);
    run_op("div ovf", OP_DIV, MIN_NEG, 32'hFFFF_FFFF);
    run_op("rem ovf", OP_REM, MIN_NEG, 32'hFFFF_FFFF);
    run_op("divu min/-1", OP_DIVU, MIN_NEG, 32'hFFFF_FFFF);

    // Flush in the 10th CALC cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.dividend = 1000; bus.divisor = 3;
    @(negedge clk); bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk); bus.flush = 1'b0;
    #1;
    check("flush busy", XLEN'(bus.busy), 0);
    check("flush stall", XLEN'(bus.stall), 0);
    count_valid(XLEN + 8, pulses);
    check("flush no valid", XLEN'(pulses), 0);
    check("flush result held", bus.result, last_res);

    // Flush wins over start in the same cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_DIVU; bus.dividend = 9; bus.divisor = 0;
    #1;
    check("flush+start stall", XLEN'(bus.stall), 0);
    @(negedge clk); bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    check("flush+start busy", XLEN'(bus.busy), 0);
    check("flush+start result", bus.result, last_res);

    // Second start while busy is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.dividend = 1000; bus.divisor = 10;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.dividend = 7; bus.divisor = 1;
    @(negedge clk); bus.start = 1'b0;
    pulses = 0; first = 0;
    for (int i = 7; i < 7 + XLEN + 12; i++) begin
      @(negedge clk);
      #1;
      if (bus.valid) begin
        pulses++;
        if (first == 0) begin
          first = i;
          check("busy-start result", bus.result, 100);
        end
      end
    end
    check("busy-start pulses", XLEN'(pulses), 1);
    check("busy-start latency", XLEN'(first), XLEN + 2);
    last_res = 100;

    // Reset in the middle of CALC.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.dividend = 77; bus.divisor = 5;
    @(negedge clk); bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst valid", XLEN'(bus.valid), 0);
    check("mid rst busy", XLEN'(bus.busy), 0);
    check("mid rst stall", XLEN'(bus.stall), 0);
    check("mid rst result", bus.result, 0);
    @(negedge clk); rst = 1'b0;
    count_valid(XLEN + 8, pulses);
    check("post rst no valid", XLEN'(pulses), 0);
    run_op("divu 9/3", OP_DIVU, 9, 3);

    for (int i = 0; i < 16; i++) begin
      div_op_e op = div_op_e'($urandom_range(0, 3));
      logic [XLEN-1:0] a = $urandom;
      logic [XLEN-1:0] b;
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = XLEN'($urandom_range(1, 15));
        2: begin b = '1; a = ($urandom_range(0, 1) != 0) ? MIN_NEG : a; end
        3: b = -XLEN'($urandom_range(1, 1000));
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
